// File: rtl/h264_intra4x4_mb_feeder_pkg.sv
// Shared constants and FSM state type for the intra4x4 macroblock feeder.
//   MB_LINES       luma lines per macroblock
//   WORDS_PER_LINE 32-bit words (4 pixels each) per macroblock line
//   WORDS_PER_MB   words per macroblock
//   FIFO_DEPTH     output buffer depth; also the read credit limit
package h264_pkg;

    localparam int MB_LINES       = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORDS_PER_MB   = MB_LINES * WORDS_PER_LINE;
    localparam int FIFO_DEPTH     = 4;

    typedef enum logic [2:0] {
        IDLE,
        ROWSTART,
        STREAM,
        ROWEND,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/h264_intra4x4_mb_feeder_if.sv
// Frame-store read bus plus intra4x4 pixel input bus.
//   mem_rd/mem_addr      read request, one word per cycle
//   mem_valid/mem_data   in-order read return, px0 in [31:23+1]
//   NEWLINE              start-of-MB-row pulse to the intra4x4 controller
//   STROBEI/DATAI        pixel word transfer, qualified by READYI
// master = feeder side, slave = frame store + intra4x4 sink side.
interface h264_intra4x4_mb_feeder_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [31:0]       mem_data;
    logic              NEWLINE;
    logic              STROBEI;
    logic [31:0]       DATAI;
    logic              READYI;

    modport master (
        output mem_rd, mem_addr, NEWLINE, STROBEI, DATAI,
        input  mem_valid, mem_data, READYI
    );

    modport slave (
        input  mem_rd, mem_addr, NEWLINE, STROBEI, DATAI,
        output mem_valid, mem_data, READYI
    );
endinterface

// File: rtl/h264_intra4x4_mb_feeder_word_fifo.sv
// 4-entry, 32-bit word FIFO with occupancy count.
//   push/push_data  write a word (caller guarantees not full)
//   pop             remove head (caller guarantees not empty)
//   head            current head word; only changes on pop or push-into-empty
//   count/empty/full occupancy
module h264_word_fifo
    import h264_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic [2:0]  count,
    output logic        empty,
    output logic        full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [31:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 3'd0);
    assign full  = (count_q == 3'(FIFO_DEPTH));
endmodule

// File: rtl/h264_intra4x4_mb_feeder.sv
// Intra4x4 macroblock feeder: reads luma from the frame store in MB order
// (word, line, mbx, mby) and streams it to the intra4x4 pixel input bus,
// pulsing NEWLINE at the start of each MB row.
//   clk, reset   clock, async active-high reset
//   start        begin a frame at word address 0 (ignored unless idle)
//   busy         frame in progress
//   frame_done   1-cycle pulse after the last word has left on STROBEI
//   bus          frame-store read bus and pixel output bus (master side)
module h264_intra4x4_mb_feeder
    import h264_pkg::*;
#(
    parameter int MB_WIDTH  = 11,
    parameter int MB_HEIGHT = 9,
    parameter int ADDR_W    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic frame_done,
    h264_intra4x4_mb_feeder_if.master bus
);
    localparam int WORD_W = $clog2(WORDS_PER_LINE);
    localparam int LINE_W = $clog2(MB_LINES);
    localparam int MBX_W  = $clog2(MB_WIDTH + 1);
    localparam int MBY_W  = $clog2(MB_HEIGHT + 1);

    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(MB_LINES - 1);
    localparam logic [MBX_W-1:0]  MBX_LAST  = MBX_W'(MB_WIDTH - 1);
    localparam logic [MBY_W-1:0]  MBY_LAST  = MBY_W'(MB_HEIGHT - 1);

    // Address steps: last word of a line -> first word of next line in the
    // same MB; MB to MB along a row; last MB base of a row -> next row base.
    localparam logic [ADDR_W-1:0] LINE_STEP =
        ADDR_W'(MB_WIDTH * WORDS_PER_LINE - (WORDS_PER_LINE - 1));
    localparam logic [ADDR_W-1:0] MB_STEP  = ADDR_W'(WORDS_PER_LINE);
    localparam logic [ADDR_W-1:0] ROW_STEP =
        ADDR_W'(WORDS_PER_LINE + (MB_LINES - 1) * MB_WIDTH * WORDS_PER_LINE);

    feeder_state_t     state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [MBX_W-1:0]  mbx_q, mbx_d;
    logic [MBY_W-1:0]  mby_q, mby_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mb_base_q, mb_base_d;
    logic [2:0]        outstanding_q, outstanding_d;

    logic        mem_rd;
    logic        mem_push;
    logic        strobe;
    logic        credit_ok;
    logic        drained;
    logic [31:0] fifo_head;
    logic [2:0]  fifo_count;
    logic        fifo_empty;
    logic        fifo_full;

    h264_word_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_push),
        .push_data (bus.mem_data),
        .pop       (strobe),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Returns with nothing in flight belong to a frame abandoned by reset.
    assign mem_push  = bus.mem_valid && (outstanding_q != 3'd0);
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < 4'(FIFO_DEPTH);
    assign drained   = fifo_empty && (outstanding_q == 3'd0);
    assign strobe    = bus.READYI && !fifo_empty &&
                       (state_q == STREAM || state_q == ROWEND || state_q == DRAIN);

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        line_d     = line_q;
        mbx_d      = mbx_q;
        mby_d      = mby_q;
        addr_d     = addr_q;
        mb_base_d  = mb_base_q;
        mem_rd     = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ROWSTART;
                    word_d    = '0;
                    line_d    = '0;
                    mbx_d     = '0;
                    mby_d     = '0;
                    addr_d    = '0;
                    mb_base_d = '0;
                end
            end
            ROWSTART: state_d = STREAM;
            STREAM: begin
                if (credit_ok) begin
                    mem_rd = 1'b1;
                    if (word_q != WORD_LAST) begin
                        word_d = word_q + WORD_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        word_d = '0;
                        if (line_q != LINE_LAST) begin
                            line_d = line_q + LINE_W'(1);
                            addr_d = addr_q + LINE_STEP;
                        end else begin
                            line_d = '0;
                            if (mbx_q != MBX_LAST) begin
                                mbx_d     = mbx_q + MBX_W'(1);
                                mb_base_d = mb_base_q + MB_STEP;
                                addr_d    = mb_base_q + MB_STEP;
                            end else begin
                                mbx_d     = '0;
                                mb_base_d = mb_base_q + ROW_STEP;
                                addr_d    = mb_base_q + ROW_STEP;
                                state_d   = ROWEND;
                            end
                        end
                    end
                end
            end
            ROWEND: begin
                // Next row's NEWLINE waits until this row has fully left.
                if (mby_q == MBY_LAST) begin
                    state_d = DRAIN;
                end else if (drained) begin
                    mby_d   = mby_q + MBY_W'(1);
                    state_d = ROWSTART;
                end
            end
            DRAIN: begin
                if (drained) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case ({mem_rd, mem_push})
            2'b10:   outstanding_d = outstanding_q + 3'd1;
            2'b01:   outstanding_d = outstanding_q - 3'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            word_q        <= '0;
            line_q        <= '0;
            mbx_q         <= '0;
            mby_q         <= '0;
            addr_q        <= '0;
            mb_base_q     <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            line_q        <= line_d;
            mbx_q         <= mbx_d;
            mby_q         <= mby_d;
            addr_q        <= addr_d;
            mb_base_q     <= mb_base_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign bus.mem_rd   = mem_rd;
    assign bus.mem_addr = addr_q;
    assign bus.NEWLINE  = (state_q == ROWSTART);
    assign bus.STROBEI  = strobe;
    assign bus.DATAI    = fifo_head;

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
        !(mem_push && fifo_full));
endmodule

// File: tb/tb_h264_intra4x4_mb_feeder.sv
module tb_h264_intra4x4_mb_feeder;
    import h264_pkg::*;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int AW = 16;
    localparam int FRAME_WORDS = W * H * WORDS_PER_MB;
    localparam int ROW_WORDS   = W * WORDS_PER_MB;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic frame_done;

    h264_intra4x4_mb_feeder_if #(.ADDR_W(AW)) bus ();

    h264_intra4x4_mb_feeder #(
        .MB_WIDTH  (W),
        .MB_HEIGHT (H),
        .ADDR_W    (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus controls: ready_mode 0 = always ready, 1 = one cycle in three, 2 = held low
    int ready_mode = 0;
    int lat_min = 1;
    int lat_max = 1;

    // frame-store model and capture
    int cyc = 0;
    int pend_addr[$];
    int pend_due[$];
    int last_due = 0;
    int mon_lat, mon_due;
    int rd_addrs[$];
    logic [31:0] got_words[$];
    int strobe_cycles[$];
    int nl_cycles[$];
    int nl_strobes[$];
    int nl_reads[$];
    int nl_and_strobe = 0;
    int max_inflight = 0;
    int fd_count = 0;
    int fd_cycle = 0;
    bit fd_prev = 0;
    logic busy_at_fd, busy_after_fd;

    int exp_addr[$];
    logic [31:0] exp_word[$];

    function automatic logic [31:0] mem_word(int a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {a16 ^ 16'hC3A5, ~a16};
    endfunction

    // Frame contents straight from the raster-to-MB address formula.
    function automatic void build_expected();
        int a;
        exp_addr.delete();
        exp_word.delete();
        for (int mby = 0; mby < H; mby++)
            for (int mbx = 0; mbx < W; mbx++)
                for (int line = 0; line < MB_LINES; line++)
                    for (int wd = 0; wd < WORDS_PER_LINE; wd++) begin
                        a = (mby * MB_LINES + line) * (W * WORDS_PER_LINE) + mbx * WORDS_PER_LINE + wd;
                        exp_addr.push_back(a);
                        exp_word.push_back(mem_word(a));
                    end
    endfunction

    function automatic int first_word_diff();
        if (got_words.size() != FRAME_WORDS) return got_words.size();
        for (int i = 0; i < FRAME_WORDS; i++)
            if (got_words[i] !== exp_word[i]) return i;
        return -1;
    endfunction

    function automatic int first_addr_diff();
        if (rd_addrs.size() != FRAME_WORDS) return rd_addrs.size();
        for (int i = 0; i < FRAME_WORDS; i++)
            if (rd_addrs[i] != exp_addr[i]) return i;
        return -1;
    endfunction

    // Frame store with in-order random latency, READYI driver and monitor.
    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        bus.READYI    = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                bus.mem_valid = 1'b0;
                bus.mem_data  = $urandom;
            end
            case (ready_mode)
                0:       bus.READYI = 1'b1;
                1:       bus.READYI = (cyc % 3 == 0);
                default: bus.READYI = 1'b0;
            endcase
            #1;
            if (bus.mem_rd) begin
                mon_lat = int'($urandom_range(lat_max, lat_min));
                mon_due = cyc + mon_lat;
                if (mon_due <= last_due) mon_due = last_due + 1;
                last_due = mon_due;
                pend_addr.push_back(int'(bus.mem_addr));
                pend_due.push_back(mon_due);
                rd_addrs.push_back(int'(bus.mem_addr));
            end
            if (pend_addr.size() > max_inflight) max_inflight = pend_addr.size();
            if (bus.STROBEI) begin
                got_words.push_back(bus.DATAI);
                strobe_cycles.push_back(cyc);
            end
            if (bus.NEWLINE) begin
                nl_cycles.push_back(cyc);
                nl_strobes.push_back(got_words.size());
                nl_reads.push_back(rd_addrs.size());
                if (bus.STROBEI) nl_and_strobe++;
            end
            if (fd_prev) busy_after_fd = busy;
            fd_prev = frame_done;
            if (frame_done) begin
                fd_count++;
                fd_cycle   = cyc;
                busy_at_fd = busy;
            end
        end
    end

    task automatic clear_capture();
        rd_addrs.delete();
        got_words.delete();
        strobe_cycles.delete();
        nl_cycles.delete();
        nl_strobes.delete();
        nl_reads.delete();
        nl_and_strobe = 0;
        max_inflight  = 0;
        fd_count      = 0;
        busy_at_fd    = 1'bx;
        busy_after_fd = 1'bx;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int base;
        base = fd_count;
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #2;
            if (fd_count > base) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_words(input int n, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #2;
            if (got_words.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [52:0] outs;
        @(negedge clk);
        #2;
        outs = {bus.mem_rd, bus.mem_addr, bus.NEWLINE, bus.STROBEI, bus.DATAI, busy, frame_done};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        outs = {bus.mem_rd, bus.mem_addr, bus.NEWLINE, bus.STROBEI, bus.DATAI, busy, frame_done};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL idle_outputs: got %h required 0", outs);
        end
    endtask

    task automatic test_single_frame();
        bit to;
        int d;
        clear_capture();
        ready_mode = 0; lat_min = 1; lat_max = 1;
        do_start();
        wait_done(3000, to);
        repeat (3) @(negedge clk);
        #2;
        total++;
        if (to) begin bad++; $display("FAIL basic_timeout: frame_done not seen, required within 3000 cycles"); end
        d = first_addr_diff();
        total++;
        if (d >= 0) begin bad++; $display("FAIL basic_addr_seq: first difference at read %0d (reads=%0d) required %0d reads in MB order", d, rd_addrs.size(), FRAME_WORDS); end
        total++;
        if (rd_addrs.size() <= 64 || rd_addrs[64] != 4) begin bad++; $display("FAIL basic_mb1_addr: read 64 got %0d required 4", rd_addrs.size() > 64 ? rd_addrs[64] : -1); end
        d = first_word_diff();
        total++;
        if (d >= 0) begin bad++; $display("FAIL basic_data_seq: first difference at word %0d (words=%0d) required %0d matching", d, got_words.size(), FRAME_WORDS); end
        total++;
        if (nl_cycles.size() != H) begin bad++; $display("FAIL basic_newline_count: got %0d required %0d", nl_cycles.size(), H); end
        total++;
        if (nl_strobes.size() < 2 || nl_strobes[1] != ROW_WORDS || nl_reads[1] != ROW_WORDS) begin
            bad++;
            $display("FAIL basic_row_barrier: strobes/reads before 2nd NEWLINE got %0d/%0d required %0d/%0d",
                     nl_strobes.size() > 1 ? nl_strobes[1] : -1, nl_reads.size() > 1 ? nl_reads[1] : -1, ROW_WORDS, ROW_WORDS);
        end
        total++;
        if (strobe_cycles.size() == 0 || nl_cycles.size() == 0 || strobe_cycles[0] - nl_cycles[0] < 2) begin
            bad++; $display("FAIL basic_first_strobe_gap: got %0d cycles required >= 2",
                            (strobe_cycles.size() > 0 && nl_cycles.size() > 0) ? strobe_cycles[0] - nl_cycles[0] : -1);
        end
        total++;
        if (strobe_cycles.size() < ROW_WORDS || strobe_cycles[ROW_WORDS-1] - strobe_cycles[0] != ROW_WORDS - 1) begin
            bad++; $display("FAIL basic_zero_bubble: row 0 span got %0d cycles required %0d",
                            strobe_cycles.size() >= ROW_WORDS ? strobe_cycles[ROW_WORDS-1] - strobe_cycles[0] : -1, ROW_WORDS - 1);
        end
        total++;
        if (nl_and_strobe != 0) begin bad++; $display("FAIL basic_newline_strobe_overlap: got %0d required 0", nl_and_strobe); end
        total++;
        if (fd_count != 1 || strobe_cycles.size() == 0 || strobe_cycles[strobe_cycles.size()-1] >= fd_cycle) begin
            bad++; $display("FAIL basic_frame_done: count %0d (required 1), must follow last STROBEI", fd_count);
        end
        total++;
        if (busy_at_fd !== 1'b1 || busy_after_fd !== 1'b0) begin
            bad++; $display("FAIL basic_busy_drop: busy at/after frame_done got %b/%b required 1/0", busy_at_fd, busy_after_fd);
        end
    endtask

    task automatic test_flow_control();
        bit to;
        int d;
        clear_capture();
        ready_mode = 1; lat_min = 1; lat_max = 5;
        do_start();
        wait_done(6000, to);
        repeat (3) @(negedge clk);
        #2;
        total++;
        if (to) begin bad++; $display("FAIL flow_timeout: frame_done not seen, required within 6000 cycles"); end
        d = first_word_diff();
        total++;
        if (d >= 0) begin bad++; $display("FAIL flow_data_seq: first difference at word %0d (words=%0d) required %0d matching", d, got_words.size(), FRAME_WORDS); end
        d = first_addr_diff();
        total++;
        if (d >= 0) begin bad++; $display("FAIL flow_addr_seq: first difference at read %0d required MB order", d); end
        total++;
        if (max_inflight > 4) begin bad++; $display("FAIL flow_outstanding: got %0d required <= 4", max_inflight); end
        total++;
        if (nl_and_strobe != 0 || nl_cycles.size() != H) begin
            bad++; $display("FAIL flow_newline: count %0d overlaps %0d required %0d and 0", nl_cycles.size(), nl_and_strobe, H);
        end
        total++;
        if (nl_strobes.size() < 2 || nl_strobes[1] != ROW_WORDS) begin
            bad++; $display("FAIL flow_row_barrier: strobes before 2nd NEWLINE got %0d required %0d", nl_strobes.size() > 1 ? nl_strobes[1] : -1, ROW_WORDS);
        end
    endtask

    task automatic test_start_while_busy();
        bit to;
        int d;
        clear_capture();
        ready_mode = 0; lat_min = 1; lat_max = 3;
        do_start();
        to = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            #2;
            if (fd_count > 0) begin
                to = 1'b0;
                break;
            end
            start = busy && (k % 37 == 5);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        total++;
        if (to) begin bad++; $display("FAIL busy_start_timeout: frame_done not seen, required within 4000 cycles"); end
        total++;
        if (fd_count != 1) begin bad++; $display("FAIL busy_start_single_done: got %0d frame_done pulses required 1", fd_count); end
        d = first_word_diff();
        total++;
        if (d >= 0) begin bad++; $display("FAIL busy_start_data_seq: first difference at word %0d (words=%0d) required %0d matching", d, got_words.size(), FRAME_WORDS); end
        total++;
        if (busy_at_fd !== 1'b1 || busy_after_fd !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL busy_start_busy: at/after/final got %b/%b/%b required 1/0/0", busy_at_fd, busy_after_fd, busy);
        end
        total++;
        if (nl_cycles.size() != H) begin bad++; $display("FAIL busy_start_newlines: got %0d required %0d", nl_cycles.size(), H); end
    endtask

    task automatic test_stall();
        bit to;
        int d, rd_at_stall, snap_rd, snap_got, changes;
        logic [31:0] snap_data;
        clear_capture();
        ready_mode = 0; lat_min = 2; lat_max = 2;
        do_start();
        wait_words(20, 2000, to);
        total++;
        if (to) begin bad++; $display("FAIL stall_reach: got %0d words required 20 before stall", got_words.size()); end
        ready_mode = 2;
        rd_at_stall = rd_addrs.size();
        repeat (10) @(negedge clk);
        #2;
        snap_rd   = rd_addrs.size();
        snap_got  = got_words.size();
        snap_data = bus.DATAI;
        changes   = 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            #2;
            if (bus.DATAI !== snap_data) changes++;
        end
        total++;
        if (rd_addrs.size() != snap_rd || rd_addrs.size() - rd_at_stall > 4) begin
            bad++; $display("FAIL stall_reads: reads during stall got %0d (late %0d) required <= 4 and none late",
                            rd_addrs.size() - rd_at_stall, rd_addrs.size() - snap_rd);
        end
        total++;
        if (rd_addrs.size() - got_words.size() != 4) begin
            bad++; $display("FAIL stall_credit: words buffered got %0d required 4", rd_addrs.size() - got_words.size());
        end
        total++;
        if (changes != 0 || got_words.size() != snap_got) begin
            bad++; $display("FAIL stall_datai_stable: changes %0d new words %0d required 0 and 0", changes, got_words.size() - snap_got);
        end
        ready_mode = 0;
        wait_done(3000, to);
        repeat (3) @(negedge clk);
        #2;
        total++;
        if (to) begin bad++; $display("FAIL stall_timeout: frame_done not seen after resume"); end
        d = first_word_diff();
        total++;
        if (d >= 0) begin bad++; $display("FAIL stall_data_seq: first difference at word %0d (words=%0d) required %0d matching", d, got_words.size(), FRAME_WORDS); end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int d, got_at, rd_at;
        logic [52:0] outs;
        clear_capture();
        ready_mode = 0; lat_min = 3; lat_max = 3;
        do_start();
        wait_words(37, 2000, to);
        total++;
        if (to) begin bad++; $display("FAIL midreset_reach: got %0d words required 37", got_words.size()); end
        reset  = 1'b1;
        got_at = got_words.size();
        rd_at  = rd_addrs.size();
        #1;
        outs = {bus.mem_rd, bus.mem_addr, bus.NEWLINE, bus.STROBEI, bus.DATAI, busy, frame_done};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL midreset_outputs: got %h required 0", outs); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 50 && pend_addr.size() > 0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        #2;
        total++;
        if (got_words.size() != got_at || rd_addrs.size() != rd_at || busy !== 1'b0 || fd_count != 0) begin
            bad++; $display("FAIL midreset_quiet: new words %0d reads %0d busy %b done %0d required 0 0 0 0",
                            got_words.size() - got_at, rd_addrs.size() - rd_at, busy, fd_count);
        end
        clear_capture();
        lat_min = 1; lat_max = 4;
        do_start();
        wait_done(3000, to);
        repeat (3) @(negedge clk);
        #2;
        total++;
        if (to) begin bad++; $display("FAIL midreset_restart_timeout: frame_done not seen"); end
        total++;
        if (rd_addrs.size() == 0 || rd_addrs[0] != 0) begin bad++; $display("FAIL midreset_first_addr: got %0d required 0", rd_addrs.size() > 0 ? rd_addrs[0] : -1); end
        d = first_word_diff();
        total++;
        if (d >= 0) begin bad++; $display("FAIL midreset_data_seq: first difference at word %0d (words=%0d) required %0d matching", d, got_words.size(), FRAME_WORDS); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        build_expected();
        repeat (2) @(negedge clk);
        test_reset();
        test_single_frame();
        test_flow_control();
        test_start_while_busy();
        test_stall();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
